store_queue: RTL and testbench
==============================

# store_queue

Parametrised in-order store queue for the memory functional unit. It holds dispatched stores until their address, data and ROB commit have all arrived, then drains them to memory in program order. It answers same-cycle load lookups with youngest-match forwarding or a stall, and it discards uncommitted stores on a pipeline flush. It sits between the address-generation FIFO and the memory port.

## Interface
- DEPTH, 4: entry count; power of two, ≥2
- ID_W, 5: ROB/reservation id width (RSV_ID_W)
- OP_W, 6: opcode width (INSTR_W)
- DATA_W, 32: data and address width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- alloc_valid/alloc_ready  in/out  1  dispatch handshake
- alloc_id  in  ID_W  store's ROB id
- alloc_op  in  OP_W  store opcode
- alloc_data  in  DATA_W  store data, or don't-care if not filled
- alloc_data_id  in  ID_W  producer tag of the store data
- alloc_data_filled  in  1  store data already valid
- cdb_valid  in  1  broadcast valid
- cdb  in  ID_W+DATA_W  {id, data}
- addr_valid  in  1  computed address arrives
- addr_id  in  ID_W  id of the store receiving the address
- addr  in  DATA_W  computed address
- commit_valid  in  1  ROB commits a store
- commit_id  in  ID_W  id of the committed store
- commit_invalidate  in  1  commit discards the store
- flush  in  1  drop all uncommitted entries
- lookup_valid  in  1  load probe
- lookup_addr  in  DATA_W  load address
- lookup_hit  out  1  forward lookup_data
- lookup_data  out  DATA_W  forwarded data
- lookup_conflict  out  1  load must retry
- mem_valid/mem_ready  out/in  1  memory write handshake
- mem_id  out  ID_W  id of draining store
- mem_op  out  OP_W  opcode of draining store
- mem_addr  out  DATA_W  address of draining store
- mem_data  out  DATA_W  data of draining store
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer with head/tail pointers of width $clog2(DEPTH). Wrap is natural modulo DEPTH.
- Entry fields: valid, id, op, addr, addr_ready, data, data_id, data_ready, committed, invalidate.
- Allocate: alloc_valid & alloc_ready writes the entry at tail and advances tail.
  - data_ready = alloc_data_filled, OR a same-cycle cdb_valid whose tag equals alloc_data_id.
  - In the bypass case, data is taken from cdb.
- alloc_ready = (count < DEPTH) & !flush. It does not depend on a same-cycle pop.
- CDB: every valid entry with !data_ready and data_id == cdb tag captures the data.
- Address: the valid entry with id == addr_id stores addr and sets addr_ready. If no entry matches, the update is ignored.
- Commit: the valid entry with id == commit_id sets committed and latches invalidate. Commits arrive in program order.
- Drain: the head entry is eligible when valid & committed & addr_ready & data_ready.
  - With invalidate clear: mem_valid = 1, and mem_* are driven from the head entry. The entry pops on mem_ready.
  - With invalidate set: mem_valid = 0 and the entry pops unconditionally that cycle.
- Lookup: purely combinational over valid, non-invalidated entries.
  - Any entry with !addr_ready → lookup_conflict = 1, lookup_hit = 0.
  - Otherwise take the youngest entry (nearest tail) with addr == lookup_addr:
    - data_ready → lookup_hit = 1, lookup_data = that entry's data.
    - !data_ready → lookup_conflict = 1.
  - No match → both outputs 0, and the load bypasses to memory.
  - All lookup outputs are 0 when lookup_valid = 0.
- Flush: clears every entry with committed = 0. tail is set to head + (number of committed entries). Committed entries are contiguous from head.

## Timing
- Reset: all entries invalid, head = tail = 0, count = 0. mem_valid, lookup_hit, lookup_conflict = 0. alloc_ready = 1 from the first cycle after reset.
- A reset mid-drain abandons the store silently.
- Allocated entry is visible to lookup and drain the cycle after acceptance.
- Minimum alloc→mem_valid latency: 1 cycle, when the entry is allocated filled and its address and commit land in the same cycle as allocation.
- mem_* stay stable while mem_valid & !mem_ready.
- Priority within one cycle:
  - Commit applies before flush, so a store committed in the flush cycle survives.
  - Flush drops any allocation.
  - A pop and a CDB/addr/commit update to the same head entry: the pop wins.
- Full: count == DEPTH, alloc_ready = 0 even if a pop occurs that cycle.
- Empty: mem_valid = 0 and lookups never hit or conflict.

## Configuration
- STQ_FWD_EN defined: forwarding as described above.
- STQ_FWD_EN undefined:
  - lookup_hit is tied to 0 and lookup_data to 0.
  - Any address match, or any unknown address, raises lookup_conflict.
  - Loads then wait until the matching stores have drained.

## Test plan
- Allocate id 3 with data 0xAA filled; addr 0x100; commit 3 → mem_valid with mem_addr = 0x100, mem_data = 0xAA; mem_ready pops it and count returns to 0.
- Two stores to 0x40, older data 0x11 and younger data 0x22, both addresses known; lookup 0x40 → lookup_hit = 1, lookup_data = 0x22. Without STQ_FWD_EN → lookup_conflict = 1.
- Allocate unfilled with data_id 7, with cdb {7, 0x55} in the same cycle → entry data 0x55 and data_ready set. A later cdb tag 7 causes no change.
- Fill DEPTH = 4 entries → alloc_ready = 0. Pop during full → no same-cycle allocation. alloc_ready = 1 on the next cycle, and tail wraps to 0.
- Four stores with ids 1, 2 committed and 3, 4 pending; assert flush → count = 2, tail = head + 2, ids 1 and 2 still drain in order.
- Commit id 5 with commit_invalidate = 1 → entry pops with mem_valid held at 0 and count decrements.

Source files
------------

// File: rtl/store_queue.sv
// store_queue: in-order store queue holding stores until address, data and commit arrive, then draining them to memory in order
// Ports: alloc_* dispatch in, cdb result broadcast, addr_* address update, commit_* ROB commit, flush,
//        lookup_* load probe (hit/data/conflict out), mem_* memory write handshake, count occupancy.
// Build option: define STQ_FWD_EN to forward store data to loads; otherwise any address overlap is a conflict.
module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 5,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [ID_W-1:0]            alloc_id,
    input  logic [OP_W-1:0]            alloc_op,
    input  logic [DATA_W-1:0]          alloc_data,
    input  logic [ID_W-1:0]            alloc_data_id,
    input  logic                       alloc_data_filled,
    input  logic                       cdb_valid,
    input  logic [ID_W+DATA_W-1:0]     cdb,
    input  logic                       addr_valid,
    input  logic [ID_W-1:0]            addr_id,
    input  logic [DATA_W-1:0]          addr,
    input  logic                       commit_valid,
    input  logic [ID_W-1:0]            commit_id,
    input  logic                       commit_invalidate,
    input  logic                       flush,
    input  logic                       lookup_valid,
    input  logic [DATA_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data,
    output logic                       lookup_conflict,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ID_W-1:0]            mem_id,
    output logic [OP_W-1:0]            mem_op,
    output logic [DATA_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  e_valid, e_addr_rdy, e_data_rdy, e_commit, e_inval, commit_hit;
    logic [ID_W-1:0]   e_id [DEPTH];
    logic [ID_W-1:0]   e_data_id [DEPTH];
    logic [OP_W-1:0]   e_op [DEPTH];
    logic [DATA_W-1:0] e_addr [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [PW-1:0]     head, tail, idx;
    logic [ID_W-1:0]   cdb_id;
    logic [DATA_W-1:0] cdb_data;
    logic              do_alloc, head_rdy, pop, byp, unk, fwd_match;
    logic [CW-1:0]     kept;
`ifdef STQ_FWD_EN
    logic              fwd_rdy;
    logic [DATA_W-1:0] fwd_data;
`endif

    assign {cdb_id, cdb_data} = cdb;

    always_comb begin
        alloc_ready = (count < CW'(DEPTH)) && !flush;
        do_alloc    = alloc_valid && alloc_ready;
        byp         = cdb_valid && cdb_id == alloc_data_id;
        head_rdy    = e_valid[head] && e_commit[head] && e_addr_rdy[head] && e_data_rdy[head];
        mem_valid   = head_rdy && !e_inval[head];
        // an invalidated store leaves without a memory write
        pop         = head_rdy && (e_inval[head] || mem_ready);
        mem_id      = e_id[head];
        mem_op      = e_op[head];
        mem_addr    = e_addr[head];
        mem_data    = e_data[head];
        // entries surviving a flush: committed (including this cycle's commit) and not popping
        kept        = '0;
        commit_hit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_hit[i] = commit_valid && e_id[i] == commit_id;
            if (e_valid[i] && (e_commit[i] || commit_hit[i]) && !(pop && PW'(i) == head))
                kept = kept + CW'(1);
        end
    end

    // walk oldest to youngest so the last address match is the youngest store
    always_comb begin
        idx       = '0;
        unk       = 1'b0;
        fwd_match = 1'b0;
`ifdef STQ_FWD_EN
        fwd_rdy   = 1'b0;
        fwd_data  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (e_valid[idx] && !e_inval[idx]) begin
                if (!e_addr_rdy[idx])
                    unk = 1'b1;
                else if (e_addr[idx] == lookup_addr) begin
                    fwd_match = 1'b1;
`ifdef STQ_FWD_EN
                    fwd_rdy   = e_data_rdy[idx];
                    fwd_data  = e_data[idx];
`endif
                end
            end
        end
`ifdef STQ_FWD_EN
        lookup_hit      = lookup_valid && !unk && fwd_match && fwd_rdy;
        lookup_data     = lookup_hit ? fwd_data : '0;
        lookup_conflict = lookup_valid && (unk || (fwd_match && !fwd_rdy));
`else
        lookup_hit      = 1'b0;
        lookup_data     = '0;
        lookup_conflict = lookup_valid && (unk || fwd_match);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && PW'(i) == head)
                    e_valid[i] <= 1'b0;
                else if (e_valid[i]) begin
                    if (cdb_valid && !e_data_rdy[i] && e_data_id[i] == cdb_id) begin
                        e_data[i]     <= cdb_data;
                        e_data_rdy[i] <= 1'b1;
                    end
                    if (addr_valid && e_id[i] == addr_id) begin
                        e_addr[i]     <= addr;
                        e_addr_rdy[i] <= 1'b1;
                    end
                    if (commit_hit[i]) begin
                        e_commit[i] <= 1'b1;
                        e_inval[i]  <= commit_invalidate;
                    end
                    if (flush && !e_commit[i] && !commit_hit[i])
                        e_valid[i] <= 1'b0;
                end else if (do_alloc && PW'(i) == tail) begin
                    // address, data and commit may all land in the allocation cycle
                    e_valid[i]    <= 1'b1;
                    e_id[i]       <= alloc_id;
                    e_op[i]       <= alloc_op;
                    e_data_id[i]  <= alloc_data_id;
                    e_data_rdy[i] <= alloc_data_filled || byp;
                    e_data[i]     <= (!alloc_data_filled && byp) ? cdb_data : alloc_data;
                    e_addr_rdy[i] <= addr_valid && addr_id == alloc_id;
                    e_addr[i]     <= addr;
                    e_commit[i]   <= commit_valid && commit_id == alloc_id;
                    e_inval[i]    <= commit_valid && commit_id == alloc_id && commit_invalidate;
                end
            end
            head <= head + PW'(pop);
            if (flush) begin
                tail  <= head + PW'(pop) + kept[PW-1:0];
                count <= kept;
            end else begin
                tail  <= tail + PW'(do_alloc);
                count <= count + CW'(do_alloc) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed vector table plus hand sequences for full/wrap, reset mid-drain and flush
module tb_store_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid, alloc_ready, alloc_data_filled;
    logic [4:0]  alloc_id, alloc_data_id;
    logic [5:0]  alloc_op;
    logic [31:0] alloc_data;
    logic        cdb_valid;
    logic [36:0] cdb;
    logic        addr_valid;
    logic [4:0]  addr_id;
    logic [31:0] addr;
    logic        commit_valid, commit_invalidate, flush;
    logic [4:0]  commit_id;
    logic        lookup_valid, lookup_hit, lookup_conflict;
    logic [31:0] lookup_addr, lookup_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_id;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr, mem_data;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;

`ifdef STQ_FWD_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    store_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id), .alloc_op(alloc_op),
        .alloc_data(alloc_data), .alloc_data_id(alloc_data_id), .alloc_data_filled(alloc_data_filled),
        .cdb_valid(cdb_valid), .cdb(cdb),
        .addr_valid(addr_valid), .addr_id(addr_id), .addr(addr),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_invalidate(commit_invalidate),
        .flush(flush),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .lookup_conflict(lookup_conflict),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_id(mem_id), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_data(mem_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        al; logic [4:0] aid; logic [31:0] ad; logic [4:0] adid; logic af;
        logic        cv; logic [4:0] cid; logic [31:0] cd;
        logic        av; logic [4:0] xid; logic [31:0] xa;
        logic        kv; logic [4:0] kid; logic ki;
        logic        fl;
        logic        lv; logic [31:0] la;
        logic        mr;
        logic        e_rdy; logic e_mv; logic [4:0] e_mid; logic [31:0] e_ma; logic [31:0] e_md;
        logic        e_hit; logic [31:0] e_ld; logic e_conf;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 32;
    vec_t tv [NV];

    function automatic logic [31:0] fd(input logic [31:0] x);
        return F ? x : 32'h0;
    endfunction

    function automatic vec_t nv();
        vec_t v;
        v = '{default: 0};
        v.e_rdy = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        alloc_valid = v.al; alloc_id = v.aid; alloc_op = {1'b0, v.aid}; alloc_data = v.ad;
        alloc_data_id = v.adid; alloc_data_filled = v.af;
        cdb_valid = v.cv; cdb = {v.cid, v.cd};
        addr_valid = v.av; addr_id = v.xid; addr = v.xa;
        commit_valid = v.kv; commit_id = v.kid; commit_invalidate = v.ki;
        flush = v.fl; lookup_valid = v.lv; lookup_addr = v.la; mem_ready = v.mr;
        @(negedge clk);
        chk({nm, " alloc_ready"}, 32'(alloc_ready), 32'(v.e_rdy));
        chk({nm, " mem_valid"}, 32'(mem_valid), 32'(v.e_mv));
        chk({nm, " count"}, 32'(count), 32'(v.e_cnt));
        chk({nm, " lookup_hit"}, 32'(lookup_hit), 32'(v.e_hit));
        chk({nm, " lookup_data"}, lookup_data, v.e_ld);
        chk({nm, " lookup_conflict"}, 32'(lookup_conflict), 32'(v.e_conf));
        if (v.e_mv) begin
            chk({nm, " mem_id"}, 32'(mem_id), 32'(v.e_mid));
            chk({nm, " mem_op"}, 32'(mem_op), 32'({1'b0, v.e_mid}));
            chk({nm, " mem_addr"}, mem_addr, v.e_ma);
            chk({nm, " mem_data"}, mem_data, v.e_md);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // al,aid,ad,adid,af, cv,cid,cd, av,xid,xa, kv,kid,ki, fl, lv,la,mr, rdy,mv,mid,ma,md, hit,ld,conf, cnt
        tv[0]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,'h100,0, 1,0,0,0,0, 0,0,0, 0};
        tv[1]  = '{1,3,'hAA,0,1, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[2]  = '{0,0,0,0,0, 0,0,0, 1,3,'h100, 0,0,0, 0, 1,'h100,0, 1,0,0,0,0, 0,0,1, 1};
        tv[3]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,3,0, 0, 1,'h100,0, 1,0,0,0,0, F,fd('hAA),!F, 1};
        tv[4]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,1,3,'h100,'hAA, 0,0,0, 1};
        tv[5]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,1,3,'h100,'hAA, 0,0,0, 1};
        tv[6]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,1, 1,1,3,'h100,'hAA, 0,0,0, 1};
        tv[7]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[8]  = '{1,8,'h11,0,1, 0,0,0, 1,8,'h40, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[9]  = '{1,9,'h22,0,1, 0,0,0, 1,9,'h40, 0,0,0, 0, 1,'h40,0, 1,0,0,0,0, F,fd('h11),!F, 1};
        tv[10] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,'h40,0, 1,0,0,0,0, F,fd('h22),!F, 2};
        tv[11] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,'h44,0, 1,0,0,0,0, 0,0,0, 2};
        tv[12] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,8,0, 0, 1,'h40,0, 1,0,0,0,0, F,fd('h22),!F, 2};
        tv[13] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,9,0, 0, 0,0,1, 1,1,8,'h40,'h11, 0,0,0, 2};
        tv[14] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,'h40,1, 1,1,9,'h40,'h22, F,fd('h22),!F, 1};
        tv[15] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[16] = '{1,10,'hDEAD,7,0, 1,7,'h55, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[17] = '{0,0,0,0,0, 1,7,'h66, 1,10,'h80, 0,0,0, 0, 1,'h80,0, 1,0,0,0,0, 0,0,1, 1};
        tv[18] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,10,0, 0, 1,'h80,0, 1,0,0,0,0, F,fd('h55),!F, 1};
        tv[19] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,1, 1,1,10,'h80,'h55, 0,0,0, 1};
        tv[20] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[21] = '{1,11,0,12,0, 0,0,0, 1,11,'h90, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[22] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,11,0, 0, 1,'h90,0, 1,0,0,0,0, 0,0,1, 1};
        tv[23] = '{0,0,0,0,0, 1,12,'h77, 0,0,0, 0,0,0, 0, 1,'h90,0, 1,0,0,0,0, 0,0,1, 1};
        tv[24] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,'h90,1, 1,1,11,'h90,'h77, F,fd('h77),!F, 1};
        tv[25] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[26] = '{1,5,'hBB,0,1, 0,0,0, 1,5,'hC0, 1,5,1, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[27] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,'hC0,0, 1,0,0,0,0, 0,0,0, 1};
        tv[28] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[29] = '{1,6,'hCC,0,1, 0,0,0, 1,6,'hD0, 1,6,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};
        tv[30] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,1, 1,1,6,'hD0,'hCC, 0,0,0, 1};
        tv[31] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,0,0,0, 0,0,0, 0};

        rst = 1'b1;
        v = nv();
        apply(v, "reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NV; i++) apply(tv[i], $sformatf("v%0d", i));

        // fill all four entries (head and tail start at 3 after seven allocations)
        for (int k = 0; k < 4; k++) begin
            v = nv(); v.al = 1; v.aid = 5'(20 + k); v.ad = 32'h1000 + 32'(k); v.af = 1;
            v.av = 1; v.xid = 5'(20 + k); v.xa = 32'h200 + 32'(4 * k); v.e_cnt = 3'(k);
            apply(v, $sformatf("fill%0d", k));
        end
        v = nv(); v.al = 1; v.aid = 24; v.ad = 32'h1010; v.af = 1; v.kv = 1; v.kid = 20;
        v.e_rdy = 0; v.e_cnt = 4;
        apply(v, "full");
        chk("full tail", 32'(dut.tail), 32'd3);
        v = nv(); v.al = 1; v.aid = 24; v.ad = 32'h1010; v.af = 1; v.mr = 1;
        v.e_rdy = 0; v.e_mv = 1; v.e_mid = 20; v.e_ma = 32'h200; v.e_md = 32'h1000; v.e_cnt = 4;
        apply(v, "pop_full");
        v = nv(); v.al = 1; v.aid = 24; v.ad = 32'h1010; v.af = 1; v.av = 1; v.xid = 24; v.xa = 32'h210;
        v.e_cnt = 3;
        apply(v, "after_pop");
        chk("wrap tail", 32'(dut.tail), 32'd0);
        v = nv(); v.kv = 1; v.kid = 21; v.e_rdy = 0; v.e_cnt = 4;
        apply(v, "commit21");
        rst = 1'b1;
        v = nv(); v.e_rdy = 0; v.e_mv = 1; v.e_mid = 21; v.e_ma = 32'h204; v.e_md = 32'h1001; v.e_cnt = 4;
        apply(v, "rst_mid_drain");
        rst = 1'b0;
        v = nv();
        apply(v, "post_rst");
        chk("post_rst head", 32'(dut.head), 32'd0);
        chk("post_rst tail", 32'(dut.tail), 32'd0);

        // flush with ids 1 and 2 committed (2 in the flush cycle) and 3, 4 pending
        v = nv(); v.al = 1; v.aid = 1; v.ad = 32'h501; v.af = 1; v.av = 1; v.xid = 1; v.xa = 32'h10;
        v.kv = 1; v.kid = 1;
        apply(v, "f1");
        v = nv(); v.al = 1; v.aid = 2; v.ad = 32'h502; v.af = 1; v.av = 1; v.xid = 2; v.xa = 32'h14;
        v.e_mv = 1; v.e_mid = 1; v.e_ma = 32'h10; v.e_md = 32'h501; v.e_cnt = 1;
        apply(v, "f2");
        v = nv(); v.al = 1; v.aid = 3; v.ad = 32'h503; v.af = 1; v.av = 1; v.xid = 3; v.xa = 32'h18;
        v.e_mv = 1; v.e_mid = 1; v.e_ma = 32'h10; v.e_md = 32'h501; v.e_cnt = 2;
        apply(v, "f3");
        v = nv(); v.al = 1; v.aid = 4; v.ad = 32'h504; v.af = 1;
        v.e_mv = 1; v.e_mid = 1; v.e_ma = 32'h10; v.e_md = 32'h501; v.e_cnt = 3;
        apply(v, "f4");
        v = nv(); v.fl = 1; v.kv = 1; v.kid = 2; v.al = 1; v.aid = 9; v.ad = 32'h999; v.af = 1;
        v.lv = 1; v.la = 32'h1C; v.e_conf = 1; v.e_rdy = 0;
        v.e_mv = 1; v.e_mid = 1; v.e_ma = 32'h10; v.e_md = 32'h501; v.e_cnt = 4;
        apply(v, "flush");
        chk("flush tail", 32'(dut.tail), 32'd2);
        chk("flush head", 32'(dut.head), 32'd0);
        v = nv(); v.mr = 1; v.lv = 1; v.la = 32'h18;
        v.e_mv = 1; v.e_mid = 1; v.e_ma = 32'h10; v.e_md = 32'h501; v.e_cnt = 2;
        apply(v, "drain1");
        v = nv(); v.mr = 1; v.e_mv = 1; v.e_mid = 2; v.e_ma = 32'h14; v.e_md = 32'h502; v.e_cnt = 1;
        apply(v, "drain2");
        v = nv();
        apply(v, "empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
